// File: rtl/p4_router_pkg.sv
// Shared types for the P4 router datapath: VNP4 user metadata, egress map entries
// and the metadata shim egress state encoding.
package p4_router_pkg;

    localparam int ING_PORT_ID_WIDTH = 8;
    localparam int EGR_SPEC_ID_WIDTH = 8;

    localparam logic [ING_PORT_ID_WIDTH-1:0] ING_PORT_INVALID = '1;

    typedef struct packed {
        logic [ING_PORT_ID_WIDTH-1:0] ing_port;
        logic [EGR_SPEC_ID_WIDTH-1:0] egr_spec;
    } USER_META_DATA_T;

    typedef struct packed {
        logic       valid;
        logic [7:0] port;
    } EGR_MAP_ENTRY_T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } meta_shim_state_t;

endpackage

// File: rtl/p4_router_meta_fifo.sv
// Synchronous show-ahead FIFO of VNP4 metadata; head visible same cycle, level updates next cycle.
// A push while full is dropped unless a pop happens in the same cycle.
module p4_router_meta_fifo
    import p4_router_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     i_push,
    input  USER_META_DATA_T          i_din,
    input  logic                     i_pop,
    output USER_META_DATA_T          o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    USER_META_DATA_T r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            w_pop;
    logic            w_push;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/p4_router_vnp4_meta_shim.sv
// Metadata shim around VNP4: zero-latency ingress tagging with port remap; egress binds queued
// metadata to packets (1-cycle bubble per packet), remaps/drops; egress stalls core_out until metadata exists.
module p4_router_vnp4_meta_shim
    import p4_router_pkg::*;
#(
    parameter int NUM_ING_PORTS   = 8,
    parameter int NUM_EGR_PORTS   = 8,
    parameter int META_FIFO_DEPTH = 16,
    parameter int DATA_BYTES      = 64
) (
    input  logic                               clk,
    input  logic                               aresetn,
    input  logic [DATA_BYTES*8-1:0]            packet_in_tdata,
    input  logic [DATA_BYTES-1:0]              packet_in_tkeep,
    input  logic                               packet_in_tlast,
    input  logic                               packet_in_tvalid,
    output logic                               packet_in_tready,
    input  logic [ING_PORT_ID_WIDTH-1:0]       in_ing_port,
    output logic [DATA_BYTES*8-1:0]            core_in_tdata,
    output logic [DATA_BYTES-1:0]              core_in_tkeep,
    output logic                               core_in_tlast,
    output logic                               core_in_tvalid,
    input  logic                               core_in_tready,
    output USER_META_DATA_T                    core_meta_in,
    output logic                               core_meta_in_valid,
    input  logic [DATA_BYTES*8-1:0]            core_out_tdata,
    input  logic [DATA_BYTES-1:0]              core_out_tkeep,
    input  logic                               core_out_tlast,
    input  logic                               core_out_tvalid,
    output logic                               core_out_tready,
    input  USER_META_DATA_T                    core_meta_out,
    input  logic                               core_meta_out_valid,
    output logic [DATA_BYTES*8-1:0]            packet_out_tdata,
    output logic [DATA_BYTES-1:0]              packet_out_tkeep,
    output logic                               packet_out_tlast,
    output logic                               packet_out_tvalid,
    input  logic                               packet_out_tready,
    output logic [ING_PORT_ID_WIDTH-1:0]       out_ing_port,
    output logic [EGR_SPEC_ID_WIDTH-1:0]       out_egr_port,
    input  logic                               cfg_wr_en,
    input  logic                               cfg_sel,
    input  logic [7:0]                         cfg_addr,
    input  logic [8:0]                         cfg_data,
    output logic [31:0]                        drop_count,
    output logic                               meta_overflow,
    output logic [$clog2(META_FIFO_DEPTH):0]   meta_fifo_level
);

    logic              r_sop;
    logic [7:0]        r_ing_map [NUM_ING_PORTS];
    EGR_MAP_ENTRY_T    r_egr_map [NUM_EGR_PORTS];
    meta_shim_state_t  r_state;
    meta_shim_state_t  w_state_nxt;
    logic [7:0]        r_out_ing;
    logic [7:0]        r_out_egr;
    logic [31:0]       r_drop_cnt;
    logic              r_overflow;

    logic              w_ing_hs;
    logic [7:0]        w_ing_id;
    USER_META_DATA_T   w_head;
    EGR_MAP_ENTRY_T    w_egr_ent;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_core_out_rdy;
    logic              w_pkt_out_vld;
    logic              w_drop_done;

    // Ingress is a straight wire; only the metadata strobe needs packet-boundary state.
    assign core_in_tdata    = packet_in_tdata;
    assign core_in_tkeep    = packet_in_tkeep;
    assign core_in_tlast    = packet_in_tlast;
    assign core_in_tvalid   = packet_in_tvalid;
    assign packet_in_tready = core_in_tready;

    assign w_ing_hs              = packet_in_tvalid && core_in_tready;
    assign core_meta_in_valid    = r_sop && w_ing_hs;
    assign core_meta_in.ing_port = w_ing_id;
    assign core_meta_in.egr_spec = '0;

    always_comb begin
        w_ing_id = ING_PORT_INVALID;
        for (int i = 0; i < NUM_ING_PORTS; i++) begin
            if (in_ing_port == 8'(i)) w_ing_id = r_ing_map[i];
        end
    end

    always_comb begin
        w_egr_ent = '0;
        for (int i = 0; i < NUM_EGR_PORTS; i++) begin
            if (w_head.egr_spec == 8'(i)) w_egr_ent = r_egr_map[i];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sop <= 1'b1;
        end else if (w_ing_hs) begin
            r_sop <= packet_in_tlast;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_ING_PORTS; i++) r_ing_map[i] <= 8'(i);
            for (int i = 0; i < NUM_EGR_PORTS; i++) r_egr_map[i] <= '{valid: 1'b1, port: 8'(i)};
        end else if (cfg_wr_en) begin
            for (int i = 0; i < NUM_ING_PORTS; i++) begin
                if (!cfg_sel && cfg_addr == 8'(i)) r_ing_map[i] <= cfg_data[7:0];
            end
            for (int i = 0; i < NUM_EGR_PORTS; i++) begin
                if (cfg_sel && cfg_addr == 8'(i)) r_egr_map[i] <= '{valid: cfg_data[8], port: cfg_data[7:0]};
            end
        end
    end

    p4_router_meta_fifo #(
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (core_meta_out_valid),
        .i_din   (core_meta_out),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (meta_fifo_level)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // The lookup cycle in IDLE deliberately moves no data, giving one bubble per packet.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_core_out_rdy = 1'b0;
        w_pkt_out_vld  = 1'b0;
        w_drop_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && core_out_tvalid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_egr_ent.valid ? FWD : DROP;
                end
            end
            FWD: begin
                w_core_out_rdy = packet_out_tready;
                w_pkt_out_vld  = core_out_tvalid;
                if (core_out_tvalid && packet_out_tready && core_out_tlast) w_state_nxt = IDLE;
            end
            DROP: begin
                w_core_out_rdy = 1'b1;
                if (core_out_tvalid && core_out_tlast) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_ing  <= '0;
            r_out_egr  <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_ing <= w_head.ing_port;
                r_out_egr <= w_egr_ent.port;
            end
            if (w_drop_done && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
            if (core_meta_out_valid && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign core_out_tready   = w_core_out_rdy;
    assign packet_out_tdata  = core_out_tdata;
    assign packet_out_tkeep  = core_out_tkeep;
    assign packet_out_tlast  = core_out_tlast;
    assign packet_out_tvalid = w_pkt_out_vld;
    assign out_ing_port      = r_out_ing;
    assign out_egr_port      = r_out_egr;
    assign drop_count        = r_drop_cnt;
    assign meta_overflow     = r_overflow;

endmodule

// File: tb/tb_p4_router_vnp4_meta_shim.sv
// Directed + randomized bench for the VNP4 metadata shim, checked against a table/queue model.
module tb_p4_router_vnp4_meta_shim;
    import p4_router_pkg::*;

    localparam int NI    = 8;
    localparam int NE    = 8;
    localparam int DEPTH = 16;
    localparam int DB    = 64;
    localparam int DW    = DB * 8;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [DW-1:0]     packet_in_tdata;
    logic [DB-1:0]     packet_in_tkeep;
    logic              packet_in_tlast;
    logic              packet_in_tvalid;
    logic              packet_in_tready;
    logic [7:0]        in_ing_port;
    logic [DW-1:0]     core_in_tdata;
    logic [DB-1:0]     core_in_tkeep;
    logic              core_in_tlast;
    logic              core_in_tvalid;
    logic              core_in_tready;
    USER_META_DATA_T   core_meta_in;
    logic              core_meta_in_valid;
    logic [DW-1:0]     core_out_tdata;
    logic [DB-1:0]     core_out_tkeep;
    logic              core_out_tlast;
    logic              core_out_tvalid;
    logic              core_out_tready;
    USER_META_DATA_T   core_meta_out;
    logic              core_meta_out_valid;
    logic [DW-1:0]     packet_out_tdata;
    logic [DB-1:0]     packet_out_tkeep;
    logic              packet_out_tlast;
    logic              packet_out_tvalid;
    logic              packet_out_tready;
    logic [7:0]        out_ing_port;
    logic [7:0]        out_egr_port;
    logic              cfg_wr_en;
    logic              cfg_sel;
    logic [7:0]        cfg_addr;
    logic [8:0]        cfg_data;
    logic [31:0]       drop_count;
    logic              meta_overflow;
    logic [4:0]        meta_fifo_level;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model: map tables, metadata queue, counters.
    logic [7:0]        m_ing      [256];
    bit                m_egr_vld  [256];
    logic [7:0]        m_egr_port [256];
    USER_META_DATA_T   mq [$];
    int                m_drop;
    bit                m_ovf;

    p4_router_vnp4_meta_shim #(
        .NUM_ING_PORTS(NI), .NUM_EGR_PORTS(NE), .META_FIFO_DEPTH(DEPTH), .DATA_BYTES(DB)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .packet_in_tdata(packet_in_tdata), .packet_in_tkeep(packet_in_tkeep),
        .packet_in_tlast(packet_in_tlast), .packet_in_tvalid(packet_in_tvalid),
        .packet_in_tready(packet_in_tready), .in_ing_port(in_ing_port),
        .core_in_tdata(core_in_tdata), .core_in_tkeep(core_in_tkeep),
        .core_in_tlast(core_in_tlast), .core_in_tvalid(core_in_tvalid),
        .core_in_tready(core_in_tready),
        .core_meta_in(core_meta_in), .core_meta_in_valid(core_meta_in_valid),
        .core_out_tdata(core_out_tdata), .core_out_tkeep(core_out_tkeep),
        .core_out_tlast(core_out_tlast), .core_out_tvalid(core_out_tvalid),
        .core_out_tready(core_out_tready),
        .core_meta_out(core_meta_out), .core_meta_out_valid(core_meta_out_valid),
        .packet_out_tdata(packet_out_tdata), .packet_out_tkeep(packet_out_tkeep),
        .packet_out_tlast(packet_out_tlast), .packet_out_tvalid(packet_out_tvalid),
        .packet_out_tready(packet_out_tready),
        .out_ing_port(out_ing_port), .out_egr_port(out_egr_port),
        .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .drop_count(drop_count), .meta_overflow(meta_overflow), .meta_fifo_level(meta_fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_ing[i]      = 8'(i);
            m_egr_vld[i]  = 1'b1;
            m_egr_port[i] = 8'(i);
        end
        mq.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
    endfunction

    function automatic logic [7:0] exp_ing_id(input logic [7:0] port);
        return (int'(port) < NI) ? m_ing[port] : 8'hFF;
    endfunction

    task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [8:0] data);
        cfg_wr_en = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_wr_en = 1'b0;
        if (!sel && int'(addr) < NI) m_ing[addr] = data[7:0];
        if (sel && int'(addr) < NE) begin
            m_egr_vld[addr]  = data[8];
            m_egr_port[addr] = data[7:0];
        end
    endtask

    task automatic send_ing(input logic [7:0] port, input int nbeats);
        int beat  = 0;
        int guard = 0;
        bit hs;
        logic [7:0] exp_id = exp_ing_id(port);
        in_ing_port = port;
        while (beat < nbeats && guard < 200) begin
            packet_in_tvalid = 1'b1;
            packet_in_tlast  = (beat == nbeats - 1);
            packet_in_tdata  = rand_data();
            core_in_tready   = 1'($urandom_range(0, 1));
            #4;
            hs = packet_in_tvalid && core_in_tready;
            check("ing_tready_pass", 64'(packet_in_tready), 64'(core_in_tready));
            check("ing_data_pass", 64'(core_in_tdata === packet_in_tdata && core_in_tvalid === 1'b1), 64'd1);
            check("ing_sop_pulse", 64'(core_meta_in_valid), 64'(hs && beat == 0));
            if (core_meta_in_valid) begin
                pulses++;
                check("ing_port_id", 64'(core_meta_in.ing_port), 64'(exp_id));
                check("ing_egr_zero", 64'(core_meta_in.egr_spec), 64'd0);
            end
            if (hs) beat++;
            tick();
            guard++;
        end
        check("ing_beats_done", 64'(beat), 64'(nbeats));
        packet_in_tvalid = 1'b0;
        packet_in_tlast  = 1'b0;
    endtask

    task automatic push_meta(input logic [7:0] ing, input logic [7:0] egr);
        core_meta_out       = '{ing_port: ing, egr_spec: egr};
        core_meta_out_valid = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(core_meta_out);
        else m_ovf = 1'b1;
        tick();
        core_meta_out_valid = 1'b0;
    endtask

    task automatic recv_egr(input int nbeats, input bit rnd_rdy);
        USER_META_DATA_T e;
        logic [DW-1:0] d [$];
        bit fwd, hs;
        int beat = 0;
        int cyc  = 0;
        for (int i = 0; i < nbeats; i++) d.push_back(rand_data());
        core_out_tvalid   = 1'b1;
        core_out_tdata    = d[0];
        core_out_tlast    = (nbeats == 1);
        packet_out_tready = 1'b1;
        #4;
        check("egr_level_pre", 64'(meta_fifo_level), 64'(mq.size()));
        check("egr_bubble_vld", 64'(packet_out_tvalid), 64'd0);
        check("egr_bubble_rdy", 64'(core_out_tready), 64'd0);
        e   = mq.pop_front();
        fwd = (int'(e.egr_spec) < NE) && m_egr_vld[e.egr_spec];
        tick();
        while (beat < nbeats && cyc < 100) begin
            core_out_tdata    = d[beat];
            core_out_tlast    = (beat == nbeats - 1);
            packet_out_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (fwd) begin
                check("fwd_vld", 64'(packet_out_tvalid), 64'd1);
                check("fwd_rdy", 64'(core_out_tready), 64'(packet_out_tready));
                check("fwd_data", 64'(packet_out_tdata === d[beat]), 64'd1);
                check("fwd_last", 64'(packet_out_tlast), 64'(beat == nbeats - 1));
                check("fwd_egr_port", 64'(out_egr_port), 64'(m_egr_port[e.egr_spec]));
                check("fwd_ing_port", 64'(out_ing_port), 64'(e.ing_port));
                hs = packet_out_tready;
            end else begin
                check("drop_vld", 64'(packet_out_tvalid), 64'd0);
                check("drop_rdy", 64'(core_out_tready), 64'd1);
                hs = 1'b1;
            end
            if (hs) beat++;
            tick();
            cyc++;
        end
        check("egr_beats_done", 64'(beat), 64'(nbeats));
        core_out_tvalid = 1'b0;
        core_out_tlast  = 1'b0;
        if (!fwd) m_drop++;
        check("drop_count", 64'(drop_count), 64'(m_drop));
        check("egr_level_post", 64'(meta_fifo_level), 64'(mq.size()));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_meta_vld"}, 64'(core_meta_in_valid), 64'd0);
        check({tag, "_drop"}, 64'(drop_count), 64'd0);
        check({tag, "_ovf"}, 64'(meta_overflow), 64'd0);
        check({tag, "_level"}, 64'(meta_fifo_level), 64'd0);
        check({tag, "_out_ing"}, 64'(out_ing_port), 64'd0);
        check({tag, "_out_egr"}, 64'(out_egr_port), 64'd0);
        check({tag, "_pkt_vld"}, 64'(packet_out_tvalid), 64'd0);
        check({tag, "_core_rdy"}, 64'(core_out_tready), 64'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        packet_in_tdata = '0; packet_in_tkeep = '1; packet_in_tlast = 1'b0; packet_in_tvalid = 1'b0;
        in_ing_port = '0; core_in_tready = 1'b0;
        core_out_tdata = '0; core_out_tkeep = '1; core_out_tlast = 1'b0; core_out_tvalid = 1'b0;
        core_meta_out = '0; core_meta_out_valid = 1'b0; packet_out_tready = 1'b0;
        cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        tick(); tick();
        check_reset_state("rst");
        aresetn = 1'b1;
        tick();

        // Ingress strobe: one pulse per packet, on the first handshake only.
        send_ing(8'd2, 1);
        send_ing(8'd5, 4);
        send_ing(8'd7, 2);
        check("ing_pulse_count", 64'(pulses), 64'd3);

        // Ingress remap, out-of-range port, and ignored out-of-range write.
        cfg_write(1'b0, 8'd3, 9'h040);
        send_ing(8'd3, 2);
        send_ing(8'd9, 1);
        cfg_write(1'b0, 8'd9, 9'h011);
        send_ing(8'd9, 1);

        // Egress remap held across a 5-beat packet with random backpressure.
        cfg_write(1'b1, 8'd1, 9'h106);
        push_meta(8'h22, 8'd1);
        recv_egr(5, 1'b1);

        // Out-of-range destination, then a cleared-valid entry.
        push_meta(8'h01, 8'd8);
        recv_egr(3, 1'b0);
        cfg_write(1'b1, 8'd2, 9'h002);
        push_meta(8'h02, 8'd2);
        recv_egr(2, 1'b0);

        // Packet waits for late metadata.
        core_out_tvalid = 1'b1;
        core_out_tlast  = 1'b0;
        packet_out_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            check("late_rdy_low", 64'(core_out_tready), 64'd0);
            check("late_vld_low", 64'(packet_out_tvalid), 64'd0);
            tick();
        end
        push_meta(8'h15, 8'd4);
        recv_egr(3, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 10; k++) begin
            push_meta(8'($urandom), 8'($urandom_range(0, 9)));
            if (k % 3 == 0) push_meta(8'($urandom), 8'($urandom_range(0, 9)));
            while (mq.size() > 0) recv_egr(int'($urandom_range(1, 4)), 1'b1);
        end

        // Overflow: 17 pushes into a 16-deep queue with nothing draining.
        for (int i = 0; i < DEPTH + 1; i++) push_meta(8'(8'h30 + i), 8'(i % 2));
        check("ovf_level", 64'(meta_fifo_level), 64'd16);
        check("ovf_sticky", 64'(meta_overflow), 64'(m_ovf));
        check("ovf_model", 64'(mq.size()), 64'd16);

        // Enter FWD with the output stalled, then reset mid-packet.
        core_out_tvalid   = 1'b1;
        core_out_tlast    = 1'b0;
        packet_out_tready = 1'b0;
        #4;
        check("stall_bubble", 64'(packet_out_tvalid), 64'd0);
        tick();
        #4;
        check("stall_fwd_vld", 64'(packet_out_tvalid), 64'd1);
        check("stall_out_ing", 64'(out_ing_port), 64'(mq[0].ing_port));
        aresetn = 1'b0;
        #1;
        model_reset();
        check_reset_state("midrst");
        core_out_tvalid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        push_meta(8'h33, 8'd1);
        recv_egr(2, 1'b0);
        send_ing(8'd3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
